// File: rtl/tnn_conv_engine.sv
// Ternary-weight KxK convolution engine: NT input-channel tiles per pixel, requantised output.
// Optional macro TNN_CONV_RELU_EN: clamp negative results to zero instead of signed saturation.
module tnn_conv_engine #(
    parameter int TN      = 4,
    parameter int TM      = 4,
    parameter int K       = 3,
    parameter int NT      = 2,
    parameter int FEAT_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SCALE_W = 8,
    parameter int BIAS_W  = 16,
    parameter int SHIFT   = 6,
    parameter int OUT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TN*K*FEAT_W-1:0]    in_col,
    input  logic                      in_row_start,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [TM*TN*K*K*2-1:0]    wt_data,
    input  logic [SCALE_W-1:0]        scale,
    input  logic [TM*BIAS_W-1:0]      bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TM*OUT_W-1:0]       out_data
);
    localparam int TILE_W = (NT > 1) ? $clog2(NT) : 1;
    localparam int POS_W  = $clog2(K + 1);
    localparam int WT_W   = TM * TN * K * K * 2;
    localparam int Y_W    = ACC_W + SCALE_W + BIAS_W + SHIFT + 2;
    localparam logic signed [Y_W-1:0] OUT_MAX = (Y_W'(1'b1) <<< (OUT_W - 1)) - Y_W'(1'b1);
`ifndef TNN_CONV_RELU_EN
    localparam logic signed [Y_W-1:0] OUT_MIN = ~OUT_MAX;
`endif
    localparam logic signed [Y_W-1:0] RND =
        (SHIFT > 0) ? (Y_W'(1'b1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : Y_W'(1'b0);

    // Ternary product: 01 -> +f, 11 -> -f, anything else -> 0.
    function automatic logic signed [ACC_W-1:0] tern_mul(input logic [1:0] code,
                                                         input logic [FEAT_W-1:0] f);
        logic signed [ACC_W-1:0] fx;
        fx = {{(ACC_W-FEAT_W){f[FEAT_W-1]}}, f};
        case (code)
            2'b01:   tern_mul = fx;
            2'b11:   tern_mul = -fx;
            default: tern_mul = {ACC_W{1'b0}};
        endcase
    endfunction

    logic [FEAT_W-1:0]        win_r [NT][TN][K][K];
    logic [WT_W-1:0]          wt_r [NT];
    logic [TILE_W-1:0]        in_tile_r;
    logic [TILE_W-1:0]        wt_tile_r;
    logic [POS_W-1:0]         pos_cnt_r;
    logic [POS_W-1:0]         pos_base_s;
    logic                     en_s;
    logic                     wt_fire_s;
    logic                     in_fire_s;
    logic                     last_beat_s;
    logic                     win_full_s;

    logic                     s0_valid_r;
    logic [TILE_W-1:0]        s0_tile_r;
    logic                     s0_last_r;
    logic                     s0_full_r;
    logic signed [ACC_W-1:0]  sum_s [TM];
    logic                     s1_valid_r;
    logic                     s1_first_r;
    logic                     s1_last_r;
    logic                     s1_full_r;
    logic signed [ACC_W-1:0]  s1_sum_r [TM];
    logic signed [ACC_W-1:0]  acc_r [TM];
    logic                     s2_fwd_r;

    logic signed [Y_W-1:0]    scale_x_s;
    logic signed [Y_W-1:0]    acc_x_s [TM];
    logic signed [Y_W-1:0]    bias_x_s [TM];
    logic signed [Y_W-1:0]    y_s [TM];
    logic [OUT_W-1:0]         y_sat_s [TM];

    assign en_s        = !(out_valid && !out_ready);
    assign wt_ready    = !s0_valid_r && !s1_valid_r && !s2_fwd_r &&
                         (in_tile_r == TILE_W'(0)) && !out_valid;
    assign wt_fire_s   = wt_valid && wt_ready;
    assign in_ready    = en_s && !wt_fire_s;
    assign in_fire_s   = in_valid && in_ready;
    assign last_beat_s = (in_tile_r == TILE_W'(NT - 1));
    assign win_full_s  = (pos_base_s >= POS_W'(K - 1));

    // Row start is honoured only on tile-0 beats and restarts the position count.
    always_comb begin
        if ((in_tile_r == TILE_W'(0)) && in_row_start) begin
            pos_base_s = POS_W'(0);
        end else begin
            pos_base_s = pos_cnt_r;
        end
    end

    // Window banks: each accepted beat shifts its tile's bank by one column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NT; t++)
                for (int n = 0; n < TN; n++)
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            win_r[t][n][r][c] <= {FEAT_W{1'b0}};
        end else if (in_fire_s) begin
            for (int n = 0; n < TN; n++) begin
                for (int r = 0; r < K; r++) begin
                    win_r[in_tile_r][n][r][0] <= in_col[(n*K+r)*FEAT_W +: FEAT_W];
                    for (int c = 1; c < K; c++)
                        win_r[in_tile_r][n][r][c] <= win_r[in_tile_r][n][r][c-1];
                end
            end
        end
    end

    // Weight banks, written round-robin by accepted weight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NT; t++) wt_r[t] <= {WT_W{1'b0}};
            wt_tile_r <= TILE_W'(0);
        end else if (wt_fire_s) begin
            wt_r[wt_tile_r] <= wt_data;
            wt_tile_r       <= (wt_tile_r == TILE_W'(NT - 1)) ? TILE_W'(0) : wt_tile_r + TILE_W'(1);
        end
    end

    // Tile and position counters; position saturates at K once the window is primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_tile_r <= TILE_W'(0);
            pos_cnt_r <= POS_W'(0);
        end else if (in_fire_s) begin
            in_tile_r <= last_beat_s ? TILE_W'(0) : in_tile_r + TILE_W'(1);
            if (last_beat_s) begin
                pos_cnt_r <= (pos_base_s == POS_W'(K)) ? POS_W'(K) : pos_base_s + POS_W'(1);
            end else begin
                pos_cnt_r <= pos_base_s;
            end
        end
    end

    // Per-output-channel sum of ternary products over the bank shifted by the last beat.
    always_comb begin
        for (int m = 0; m < TM; m++) begin
            sum_s[m] = {ACC_W{1'b0}};
            for (int n = 0; n < TN; n++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        sum_s[m] = sum_s[m] + tern_mul(wt_r[s0_tile_r][2*(((m*TN+n)*K+r)*K+c) +: 2],
                                                       win_r[s0_tile_r][n][r][c]);
        end
    end

    // Requantise: scale, add shifted bias plus rounding, arithmetic shift, then clamp.
    always_comb begin
        scale_x_s = {{(Y_W-SCALE_W){1'b0}}, scale};
        for (int m = 0; m < TM; m++) begin
            acc_x_s[m]  = {{(Y_W-ACC_W){acc_r[m][ACC_W-1]}}, acc_r[m]};
            bias_x_s[m] = {{(Y_W-BIAS_W){bias[m*BIAS_W+BIAS_W-1]}}, bias[m*BIAS_W +: BIAS_W]};
            y_s[m]      = (acc_x_s[m] * scale_x_s + (bias_x_s[m] <<< SHIFT) + RND) >>> SHIFT;
`ifdef TNN_CONV_RELU_EN
            if (y_s[m][Y_W-1]) begin
                y_sat_s[m] = {OUT_W{1'b0}};
            end else if (y_s[m] > OUT_MAX) begin
                y_sat_s[m] = OUT_MAX[OUT_W-1:0];
            end else begin
                y_sat_s[m] = y_s[m][OUT_W-1:0];
            end
`else
            if (y_s[m] > OUT_MAX) begin
                y_sat_s[m] = OUT_MAX[OUT_W-1:0];
            end else if (y_s[m] < OUT_MIN) begin
                y_sat_s[m] = OUT_MIN[OUT_W-1:0];
            end else begin
                y_sat_s[m] = y_s[m][OUT_W-1:0];
            end
`endif
        end
    end

    // Three-stage pipeline (sum, accumulate, requantise) advancing together on en_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_r <= 1'b0;
            s0_tile_r  <= TILE_W'(0);
            s0_last_r  <= 1'b0;
            s0_full_r  <= 1'b0;
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_full_r  <= 1'b0;
            s2_fwd_r   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= {(TM*OUT_W){1'b0}};
            for (int m = 0; m < TM; m++) begin
                s1_sum_r[m] <= {ACC_W{1'b0}};
                acc_r[m]    <= {ACC_W{1'b0}};
            end
        end else if (en_s) begin
            s0_valid_r <= in_fire_s;
            s0_tile_r  <= in_tile_r;
            s0_last_r  <= last_beat_s;
            s0_full_r  <= win_full_s;
            s1_valid_r <= s0_valid_r;
            s1_first_r <= (s0_tile_r == TILE_W'(0));
            s1_last_r  <= s0_last_r;
            s1_full_r  <= s0_full_r;
            for (int m = 0; m < TM; m++) s1_sum_r[m] <= sum_s[m];
            if (s1_valid_r) begin
                for (int m = 0; m < TM; m++)
                    acc_r[m] <= s1_first_r ? s1_sum_r[m] : acc_r[m] + s1_sum_r[m];
            end
            s2_fwd_r  <= s1_valid_r && s1_last_r && s1_full_r;
            out_valid <= s2_fwd_r;
            if (s2_fwd_r) begin
                for (int m = 0; m < TM; m++) out_data[m*OUT_W +: OUT_W] <= y_sat_s[m];
            end
        end
    end

endmodule

// File: tb/tb_tnn_conv_engine.sv
// Directed self-checking bench for tnn_conv_engine at default parameters (TN=TM=4, K=3, NT=2).
module tb_tnn_conv_engine;
    localparam int TN = 4, TM = 4, K = 3, NT = 2, FEAT_W = 8, ACC_W = 24;
    localparam int SCALE_W = 8, BIAS_W = 16, SHIFT = 6, OUT_W = 8;
    localparam int WT_W  = TM * TN * K * K * 2;
    localparam int COL_W = TN * K * FEAT_W;

`ifdef TNN_CONV_RELU_EN
    localparam logic [31:0] NEG_EXP  = 32'h0000_0000;
    localparam logic [31:0] BIAS_EXP = 32'h0000_0201;
`else
    localparam logic [31:0] NEG_EXP  = 32'h8080_8080;
    localparam logic [31:0] BIAS_EXP = 32'h00FE_0201;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid, in_ready, in_row_start;
    logic [COL_W-1:0]        in_col;
    logic                    wt_valid, wt_ready;
    logic [WT_W-1:0]         wt_data;
    logic [SCALE_W-1:0]      scale;
    logic [TM*BIAS_W-1:0]    bias;
    logic                    out_valid, out_ready;
    logic [TM*OUT_W-1:0]     out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    logic [31:0] got_q [$];
    int          got_cyc_q [$];

    tnn_conv_engine #(
        .TN(TN), .TM(TM), .K(K), .NT(NT), .FEAT_W(FEAT_W), .ACC_W(ACC_W),
        .SCALE_W(SCALE_W), .BIAS_W(BIAS_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col), .in_row_start(in_row_start),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .scale(scale), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every accepted result together with the cycle it was first presented.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WT_W-1:0] make_wt(input logic [1:0] code);
        logic [WT_W-1:0] v;
        for (int i = 0; i < TM * TN * K * K; i++) v[2*i +: 2] = code;
        return v;
    endfunction

    function automatic logic [COL_W-1:0] make_col(input logic [7:0] f);
        logic [COL_W-1:0] v;
        for (int i = 0; i < TN * K; i++) v[i*FEAT_W +: FEAT_W] = f;
        return v;
    endfunction

    task automatic send_beat(input logic [COL_W-1:0] col, input logic rs);
        bit ok;
        ok = 1'b0;
        in_col = col;
        in_row_start = rs;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_row_start = 1'b0;
        if (!ok) chk("beat_timeout", 64'd0, 64'd1);
        else last_acc_cyc = cyc;
    endtask

    task automatic send_pos(input logic [7:0] f, input logic rs);
        send_beat(make_col(f), rs);
        send_beat(make_col(f), 1'b0);
    endtask

    task automatic load_wt(input logic [WT_W-1:0] d);
        bit ok;
        ok = 1'b0;
        wt_data = d;
        wt_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = wt_ready;
            @(posedge clk);
            #1;
        end
        wt_valid = 1'b0;
        if (!ok) chk("wt_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input int n,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        logic [31:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk($sformatf("%s_count", tag), got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) chk($sformatf("%s_out%0d", tag, i), got_q[i], e[i]);
        end
        got_q.delete();
        got_cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_row_start = 1'b0; in_col = '0;
        wt_valid = 1'b0; wt_data = '0;
        scale = 8'd1; bias = '0; out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_wt_ready", wt_ready, 1'b1);
        chk("idle_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // All +1 weights, unit features: 72 -> (72+32)>>6 = 1, three cycles after the last beat.
        load_wt(make_wt(2'b01));
        load_wt(make_wt(2'b01));
        send_pos(8'd1, 1'b1);
        send_pos(8'd1, 1'b0);
        send_pos(8'd1, 1'b0);
        drain();
        if (got_cyc_q.size() > 0) chk("t1_latency", got_cyc_q[0] - last_acc_cyc, 3);
        expect_outs("t1", 1, 32'h0101_0101, 32'h0, 32'h0);

        // Opposing tiles cancel; then per-channel bias {0,-2,2,1}.
        load_wt(make_wt(2'b01));
        load_wt(make_wt(2'b11));
        send_pos(8'd5, 1'b0);
        send_pos(8'd5, 1'b0);
        send_pos(8'd5, 1'b0);
        drain();
        expect_outs("t2_cancel", 3, 32'h0, 32'h0, 32'h0);
        bias = {16'h0000, 16'hFFFE, 16'h0002, 16'h0001};
        send_pos(8'd5, 1'b0);
        drain();
        expect_outs("t2_bias", 1, BIAS_EXP, 32'h0, 32'h0);

        // Saturation both ways with scale 255.
        bias = '0;
        scale = 8'd255;
        load_wt(make_wt(2'b01));
        load_wt(make_wt(2'b01));
        send_pos(8'd127, 1'b0);
        send_pos(8'd127, 1'b0);
        send_pos(8'd127, 1'b0);
        drain();
        expect_outs("t3_pos_sat", 3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
        load_wt(make_wt(2'b11));
        load_wt(make_wt(2'b11));
        send_pos(8'd127, 1'b0);
        send_pos(8'd127, 1'b0);
        send_pos(8'd127, 1'b0);
        drain();
        expect_outs("t3_neg_sat", 3, NEG_EXP, NEG_EXP, NEG_EXP);

        // Mixed windows while 127s shift out: 6120->96, 3096->48, 72->1.
        scale = 8'd1;
        load_wt(make_wt(2'b01));
        load_wt(make_wt(2'b01));
        send_pos(8'd1, 1'b0);
        send_pos(8'd1, 1'b0);
        send_pos(8'd1, 1'b0);
        drain();
        expect_outs("t4_mix", 3, 32'h6060_6060, 32'h3030_3030, 32'h0101_0101);

        // Backpressure: hold out_ready low for 5 cycles with results in flight.
        out_ready = 1'b0;
        fork
            begin
                send_pos(8'd64, 1'b0);
                send_pos(8'd64, 1'b0);
                send_pos(8'd64, 1'b0);
            end
            begin
                for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
                chk("t4_stall_seen", out_valid, 1'b1);
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_stall_in_ready", in_ready, 1'b0);
                    chk("t4_stall_valid", out_valid, 1'b1);
                    chk("t4_stall_data", out_data, 32'h1919_1919);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        expect_outs("t4_release", 3, 32'h1919_1919, 32'h3030_3030, 32'h4848_4848);

        // Row restart: only the third position of the new row produces output.
        send_pos(8'd1, 1'b1);
        send_pos(8'd1, 1'b0);
        send_pos(8'd1, 1'b0);
        drain();
        expect_outs("t5_row", 1, 32'h0101_0101, 32'h0, 32'h0);

        // Coincident weight and feature beats while idle: the weight beat wins.
        scale = 8'd16;
        wt_data = make_wt(2'b01);
        wt_valid = 1'b1;
        in_col = make_col(8'd1);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t6_wt_ready", wt_ready, 1'b1);
        chk("t6_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        wt_valid = 1'b0;
        in_valid = 1'b0;
        load_wt(make_wt(2'b00));
        send_pos(8'd1, 1'b0);
        drain();
        expect_outs("t6_coincide", 1, 32'h0909_0909, 32'h0, 32'h0);

        // Asynchronous reset mid-stream clears output and weights.
        out_ready = 1'b0;
        send_pos(8'd1, 1'b0);
        send_pos(8'd1, 1'b0);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        chk("t7_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", out_valid, 1'b0);
        chk("t7_rst_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t7_wt_ready", wt_ready, 1'b1);
        @(posedge clk); #1;
        send_pos(8'd5, 1'b1);
        send_pos(8'd5, 1'b0);
        send_pos(8'd5, 1'b0);
        drain();
        expect_outs("t7_zero_wt", 1, 32'h0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
